// File: rtl/braille_tx.sv
`default_nettype none
// ============================================================================
// Module      : braille_tx
// Description : Turns classifier letter results (0..25 = a..z) into six-dot
//               braille cells, queues the encoded bytes {2'b01, dots} in a
//               small FIFO and shifts them out as UART frames (8N1, or 8E1
//               when BRAILLE_TX_PARITY_EN is defined). Invalid class indices
//               are sent as 0x80 and leave the displayed cell untouched.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//               FIFO_DEPTH    queued result bytes (power of two, >= 2)
// Macro       : BRAILLE_TX_PARITY_EN  adds an even-parity bit after the data
// Ports       : clk         in   system clock, rising edge
//               reset_n     in   asynchronous active-low reset
//               i_valid     in   one-cycle strobe, result on i_alpha
//               i_alpha     in   [7:0] class index
//               o_tx        out  UART line, idle high, registered
//               o_busy      out  frame in flight or FIFO non-empty
//               o_dots      out  [5:0] last accepted cell (bit0 = dot1)
//               o_overflow  out  sticky, a result was dropped
// ============================================================================
module braille_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_valid,
   input  logic [7:0] i_alpha,
   output logic       o_tx,
   output logic       o_busy,
   output logic [5:0] o_dots,
   output logic       o_overflow
);

   localparam int             PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [15:0]    BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0] CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef BRAILLE_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   // ------------------------------------------------------------------
   // Letter to braille cell encoding
   // ------------------------------------------------------------------
   logic [5:0] cell_dots;
   logic       cell_ok;
   logic [7:0] push_byte;

   always_comb begin
      cell_ok   = 1'b1;
      cell_dots = 6'h00;
      case (i_alpha)
         8'd0:    cell_dots = 6'h01;   // a
         8'd1:    cell_dots = 6'h03;   // b
         8'd2:    cell_dots = 6'h09;   // c
         8'd3:    cell_dots = 6'h19;   // d
         8'd4:    cell_dots = 6'h11;   // e
         8'd5:    cell_dots = 6'h0B;   // f
         8'd6:    cell_dots = 6'h1B;   // g
         8'd7:    cell_dots = 6'h13;   // h
         8'd8:    cell_dots = 6'h0A;   // i
         8'd9:    cell_dots = 6'h1A;   // j
         8'd10:   cell_dots = 6'h05;   // k
         8'd11:   cell_dots = 6'h07;   // l
         8'd12:   cell_dots = 6'h0D;   // m
         8'd13:   cell_dots = 6'h1D;   // n
         8'd14:   cell_dots = 6'h15;   // o
         8'd15:   cell_dots = 6'h0F;   // p
         8'd16:   cell_dots = 6'h1F;   // q
         8'd17:   cell_dots = 6'h17;   // r
         8'd18:   cell_dots = 6'h0E;   // s
         8'd19:   cell_dots = 6'h1E;   // t
         8'd20:   cell_dots = 6'h25;   // u
         8'd21:   cell_dots = 6'h27;   // v
         8'd22:   cell_dots = 6'h3A;   // w (not in the regular u..z pattern)
         8'd23:   cell_dots = 6'h2D;   // x
         8'd24:   cell_dots = 6'h3D;   // y
         8'd25:   cell_dots = 6'h35;   // z
         default: cell_ok   = 1'b0;
      endcase
   end

   assign push_byte = cell_ok ? {2'b01, cell_dots} : 8'h80;

   // ------------------------------------------------------------------
   // Result FIFO
   // ------------------------------------------------------------------
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_head;
   logic             push;
   logic             pop;
   logic             drop;

   assign fifo_full  = (fifo_count == CNT_FULL);
   assign fifo_empty = (fifo_count == '0);
   assign fifo_head  = fifo_mem[rd_ptr];

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   // pop only depends on registered state, so there is no loop here.
   assign push = i_valid && (!fifo_full || pop);
   assign drop = i_valid && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= push_byte;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         o_dots     <= 6'h00;
         o_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push && cell_ok) begin
            o_dots <= cell_dots;
         end
         if (drop) begin
            o_overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // UART transmit FSM
   // ------------------------------------------------------------------
   state_t      state;
   state_t      state_next;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_reg;
   logic        tx_next;
   logic        baud_done;
`ifdef BRAILLE_TX_PARITY_EN
   logic        par_bit;
`endif

   assign baud_done = (baud_cnt == BAUD_LAST);
   assign o_busy    = (state != IDLE) || !fifo_empty;

   // tx_next is the line level for the current state; registering it makes
   // o_tx glitch-free and lags the state by one cycle, which gives the
   // two-edge accept-to-start-bit latency.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      tx_next    = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (baud_done) begin
               state_next = DATA;
            end
         end
         DATA: begin
            tx_next = shift_reg[0];
            if (baud_done && (bit_cnt == 3'd7)) begin
`ifdef BRAILLE_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef BRAILLE_TX_PARITY_EN
         PARITY: begin
            tx_next = par_bit;
            if (baud_done) begin
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            tx_next = 1'b1;
            if (baud_done) begin
               // Chain straight into the next frame so there is no idle gap.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         o_tx      <= 1'b1;
         baud_cnt  <= 16'd0;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'h00;
`ifdef BRAILLE_TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         state <= state_next;
         o_tx  <= tx_next;

         if ((state == IDLE) || baud_done) begin
            baud_cnt <= 16'd0;
         end else begin
            baud_cnt <= baud_cnt + 16'd1;
         end

         if ((state == DATA) && baud_done) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end

         if (pop) begin
            shift_reg <= fifo_head;
            bit_cnt   <= 3'd0;
`ifdef BRAILLE_TX_PARITY_EN
            par_bit   <= ^fifo_head;
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/braille_tx.md
BRAILLE_TX -- requirements
Module: braille_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued result bytes; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  one-cycle strobe meaning a classifier result is present on i_alpha.
REQ-006 SHALL have port i_alpha  input  8  class index: 0..25 = letters a..z; 26..255 = invalid.
REQ-007 SHALL have port o_tx  output  1  UART serial line, idle high.
REQ-008 SHALL have port o_busy  output  1  high while a frame is being shifted or the FIFO is non-empty.
REQ-009 SHALL have port o_dots  output  6  last accepted braille cell (bit0 = dot1 .. bit5 = dot6), for LED/actuator display.
REQ-010 SHALL have port o_overflow  output  1  sticky flag, set when a result is dropped.

Function
REQ-011 Encoding SHALL be registered on accept; byte = {2'b01, dots}; an invalid index SHALL produce byte 0x80 and leave o_dots unchanged.
REQ-012 Dot table a..j: a 0x01, b 0x03, c 0x09, d 0x19, e 0x11, f 0x0B, g 0x1B, h 0x13, i 0x0A, j 0x1A.
REQ-013 Dot table k..t: the a..j value OR 0x04 (k=0x05 .. t=0x1E).
REQ-014 Dot table u,v,x,y,z: the a,b,c,d,e value OR 0x24 (u=0x25, v=0x27, x=0x2D, y=0x3D, z=0x35); w = 0x3A.
REQ-015 The FIFO write SHALL occur at the clk edge that samples i_valid high, provided the FIFO is not full or a pop occurs in the same cycle.
REQ-016 When i_valid is high, the FIFO is full and no pop occurs in that cycle, the result SHALL be dropped, the FIFO SHALL be unchanged, and o_overflow SHALL be set.
REQ-017 The TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 FSM transition from IDLE: when the FIFO is non-empty, pop the head byte and go to START; o_tx SHALL be low on the 2nd edge after the accepting edge when previously idle.
REQ-019 FSM transition from START: after CLKS_PER_BIT cycles, go to DATA.
REQ-020 FSM transition from DATA: shift 8 bits LSB first, each bit held CLKS_PER_BIT cycles, then go to PARITY (if enabled) or STOP.
REQ-021 FSM transition from STOP: after CLKS_PER_BIT cycles high, go to IDLE; back-to-back frames SHALL start a new START with no extra idle cycle.
REQ-022 o_tx SHALL be a registered output, glitch-free; the bit counter SHALL be 3 bits, the baud counter SHALL be 16 bits and wrap only at CLKS_PER_BIT-1.
REQ-023 A simultaneous push and pop while full SHALL accept the push; a simultaneous push and pop while empty SHALL NOT be possible (pop requires non-empty at the prior edge).
REQ-024 o_dots SHALL update on the accepting edge, independent of TX progress.

Reset
REQ-025 On reset_n low, the following SHALL take effect immediately, mid-frame included: o_tx=1, o_busy=0, o_dots=0, o_overflow=0, FSM=IDLE, FIFO empty, all counters 0.
REQ-026 On reset release, no partial frame SHALL be resumed.

Configuration
REQ-027 Macro BRAILLE_TX_PARITY_EN SHALL control the PARITY state: when defined, an even-parity bit over the 8 data bits SHALL be sent after DATA, giving an 11-bit frame.
REQ-028 When BRAILLE_TX_PARITY_EN is undefined, the PARITY state SHALL be absent and the frame SHALL be 10 bits (8N1).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single letter: i_alpha=0 strobe -> o_tx low 2 edges later, data 0x41 LSB first, stop high; o_dots=0x01; 40-cycle frame (44 with parity, parity bit 0).
REQ-030 Table sweep: i_alpha=22 (w) -> byte 0x7A, i_alpha=25 (z) -> 0x75, i_alpha=10 (k) -> 0x45, i_alpha=200 -> 0x80 with o_dots unchanged.
REQ-031 Burst: 6 strobes on consecutive cycles -> first 5 bytes transmitted back-to-back with no idle gap (1 in shifter + 4 queued), 6th dropped, o_overflow=1 and stays 1.
REQ-032 Reset mid-frame: assert reset_n during DATA bit 3 -> o_tx=1 asynchronously, o_busy=0; after release, a new strobe with i_alpha=1 -> clean frame 0x43.
REQ-033 Full plus pop: FIFO full, strobe on the exact cycle the FSM pops -> accepted, no overflow, all bytes delivered in order.
